regfile_dump_ctrl: RTL and testbench

Hardware controller that snapshots the core's 32-entry register file and streams it out over a valid/ready port. It sits beside the datapath: it observes write-back and the current instruction, freezes the core with `halt`, sequences a dedicated register-file debug read port through r0..r(NREG-1), and parks the core permanently after an EBREAK. It replaces simulation-only register dumping with a synthesizable path usable on FPGA.

---
 rtl/regdump_pkg.sv | 19 +
 rtl/regdump_stream_stage.sv | 54 +++++
 rtl/regfile_dump_ctrl.sv | 165 ++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump controller.
// Optional write-back trigger: define REGDUMP_WB_TRIGGER_EN.
package regdump_pkg;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DUMP   = 2'd1,
    ST_PARKED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_REQ    = 2'd0,
    CAUSE_WB     = 2'd1,
    CAUSE_EBREAK = 2'd2
  } cause_e;

endpackage

// File: rtl/regdump_stream_stage.sv
// Registered valid/ready output stage for snapshot beats.
// Holds the current beat stable while the consumer stalls.
module regdump_stream_stage
  import regdump_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_data,
  input  logic [AW-1:0]   i_idx,
  input  logic            i_last,
  input  cause_e          i_cause,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic [AW-1:0]   o_idx,
  output logic            o_last,
  output logic [1:0]      o_cause
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [AW-1:0]   r_idx;
  logic            r_last;
  cause_e          r_cause;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_cause <= CAUSE_REQ;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_idx   <= i_idx;
      r_last  <= i_last;
      r_cause <= i_cause;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;
  assign o_last  = r_last;
  assign o_cause = r_cause;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Snapshots the register file over a valid/ready stream, halting the core.
// Define REGDUMP_WB_TRIGGER_EN to snapshot on every write-back to rd!=0.
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic            dump_req,
  output logic            halt,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_idx,
  output logic [XLEN-1:0] out_data,
  output logic            out_last,
  output logic [1:0]      out_cause,
  output logic            halted,
  output logic [15:0]     dump_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_idx;
  logic          r_issued;
  logic          r_pend;
  logic          r_park;
  logic          r_halt;
  logic          r_halted;
  cause_e        r_cause;
  logic [15:0]   r_count;

  logic   w_eb;
  logic   w_wb;
  logic   w_done;
  logic   w_load;
  logic   w_start;
  logic   w_halt_d;
  logic   w_pend_any;
  logic   w_last_rd;
  cause_e w_start_cause;

  assign w_eb = instr_valid && (instr == EBREAK_INSN);

`ifdef REGDUMP_WB_TRIGGER_EN
  assign w_wb = wb_en && (wb_rd != '0);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_rd};
  assign w_wb        = 1'b0;
`endif

  assign w_pend_any = r_pend || dump_req;
  assign w_last_rd  = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_start_cause = CAUSE_REQ;
    unique case (r_state)
      ST_IDLE: begin
        if (w_eb || w_wb || dump_req) begin
          w_next        = ST_DUMP;
          w_start       = 1'b1;
          w_start_cause = w_eb ? CAUSE_EBREAK :
                          w_wb ? CAUSE_WB : CAUSE_REQ;
        end
      end
      ST_DUMP: begin
        if (w_done) begin
          // merged mid-dump requests restart without an idle gap
          if (w_pend_any) w_start = 1'b1;
          else if (r_park) w_next = ST_PARKED;
          else w_next = ST_IDLE;
        end
      end
      ST_PARKED: begin
        if (dump_req) begin
          w_next  = ST_DUMP;
          w_start = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state == ST_DUMP) && !r_issued &&
             (!out_valid || out_ready);
    w_done = (r_state == ST_DUMP) && out_valid &&
             out_ready && out_last;
    w_halt_d = (w_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx    <= '0;
      r_issued <= 1'b0;
      r_pend   <= 1'b0;
      r_park   <= 1'b0;
      r_halt   <= 1'b0;
      r_halted <= 1'b0;
      r_cause  <= CAUSE_REQ;
      r_count  <= '0;
    end else begin
      r_halt <= w_halt_d;
      if (w_next == ST_PARKED) r_halted <= 1'b1;
      if (w_start) begin
        r_idx    <= '0;
        r_issued <= 1'b0;
        r_cause  <= w_start_cause;
        if (w_start_cause == CAUSE_EBREAK) r_park <= 1'b1;
      end else if (w_load) begin
        r_idx <= r_idx + 1'b1;
        if (w_last_rd) r_issued <= 1'b1;
      end
      if (r_state == ST_DUMP)
        r_pend <= w_done ? 1'b0 : w_pend_any;
      else
        r_pend <= 1'b0;
      if (w_done && (r_count != 16'hFFFF))
        r_count <= r_count + 16'd1;
    end
  end

  regdump_stream_stage #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_stage (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_data  (rf_rdata),
    .i_idx   (r_idx),
    .i_last  (w_last_rd),
    .i_cause (r_cause),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_idx   (out_idx),
    .o_last  (out_last),
    .o_cause (out_cause)
  );

  assign rf_raddr   = r_idx;
  assign halt       = r_halt;
  assign halted     = r_halted;
  assign dump_count = r_count;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file.
// Write-back trigger checks follow REGDUMP_WB_TRIGGER_EN.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] instr;
  logic        instr_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        dump_req;
  logic        halt;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  out_cause;
  logic        halted;
  logic [15:0] dump_count;

  logic [31:0] rf [32];
  bit          ov_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  int          e;

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  regfile_dump_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr       (instr),
    .instr_valid (instr_valid),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .dump_req    (dump_req),
    .halt        (halt),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_cause   (out_cause),
    .halted      (halted),
    .dump_count  (dump_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input int k);
    if (ov_en && k == 5) return 32'hDEADBEEF;
    return 32'(k * 4);
  endfunction

  // Starts on a negedge; consumes one full snapshot, returns edges used.
  task automatic run_dump(input logic [1:0] cause, input bit tog,
                          output int edges);
    int          exp_idx;
    bit          done;
    bit          stalled;
    logic [31:0] hd;
    logic [4:0]  hi;
    exp_idx = 0;
    done    = 1'b0;
    stalled = 1'b0;
    hd      = '0;
    hi      = '0;
    edges   = 0;
    while (!done && edges < 200) begin
      out_ready = tog ? (edges % 2 == 1) : 1'b1;
      if (stalled) begin
        chk("stall_data", out_data, hd);
        chk("stall_idx", 32'(out_idx), 32'(hi));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk("beat_idx", 32'(out_idx), 32'(exp_idx));
          chk("beat_data", out_data, exp_val(exp_idx));
          chk("beat_last", 32'(out_last), 32'(exp_idx == 31));
          chk("beat_cause", 32'(out_cause), 32'(cause));
          done = (exp_idx == 31);
          exp_idx++;
        end else begin
          stalled = 1'b1;
          hd      = out_data;
          hi      = out_idx;
        end
      end
      @(negedge clk);
      edges++;
    end
    if (!done) chk("dump_timeout", 32'(exp_idx), 32'd32);
    out_ready = 1'b1;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'(k * 4);
    resetn      = 1'b0;
    instr       = 32'h0000_0013;
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = '0;
    dump_req    = 1'b0;
    out_ready   = 1'b1;
    #3;
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(dump_count), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // plain request, ready held high
    pulse_req();
    chk("t1_halt_e0", 32'(halt), 32'd1);
    chk("t1_valid_e0", 32'(out_valid), 32'd0);
    run_dump(2'd0, 1'b0, e);
    exp_cnt++;
    chk("t1_edges", 32'(e), 32'd33);
    chk("t1_halt_end", 32'(halt), 32'd0);
    chk("t1_count", 32'(dump_count), 32'(exp_cnt));
    chk("t1_valid_end", 32'(out_valid), 32'd0);

    // alternating backpressure
    pulse_req();
    run_dump(2'd0, 1'b1, e);
    exp_cnt++;
    chk("t2_edges", 32'(e), 32'd64);
    chk("t2_count", 32'(dump_count), 32'(exp_cnt));
    chk("t2_halt_end", 32'(halt), 32'd0);

    // write-back to r0 never triggers
    @(negedge clk);
    wb_en = 1'b1;
    wb_rd = 5'd0;
    @(negedge clk);
    wb_en = 1'b0;
    chk("wb_r0_halt", 32'(halt), 32'd0);

    // write-back to r5 commits DEADBEEF
    @(negedge clk);
    wb_en  = 1'b1;
    wb_rd  = 5'd5;
    rf[5]  = 32'hDEADBEEF;
    ov_en  = 1'b1;
    @(negedge clk);
    wb_en = 1'b0;
`ifdef REGDUMP_WB_TRIGGER_EN
    chk("wb_halt", 32'(halt), 32'd1);
    run_dump(2'd1, 1'b0, e);
    exp_cnt++;
    chk("wb_edges", 32'(e), 32'd33);
`else
    chk("wb_off_halt", 32'(halt), 32'd0);
    chk("wb_off_valid", 32'(out_valid), 32'd0);
`endif
    chk("wb_count", 32'(dump_count), 32'(exp_cnt));

    // EBREAK together with a request: one snapshot, then parked
    @(negedge clk);
    instr       = 32'h0010_0073;
    instr_valid = 1'b1;
    dump_req    = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 32'h0000_0013;
    dump_req    = 1'b0;
    chk("eb_halt_e0", 32'(halt), 32'd1);
    run_dump(2'd2, 1'b0, e);
    exp_cnt++;
    chk("eb_edges", 32'(e), 32'd33);
    chk("eb_halted", 32'(halted), 32'd1);
    chk("eb_count", 32'(dump_count), 32'(exp_cnt));
    repeat (3) @(negedge clk);
    chk("eb_single", 32'(out_valid), 32'd0);
    chk("eb_halt_held", 32'(halt), 32'd1);

    // parked request plus a mid-dump request: back-to-back snapshots
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dump_req = 1'b0;
    run_dump(2'd0, 1'b0, e);
    exp_cnt++;
    chk("b2b_halt_gap", 32'(halt), 32'd1);
    run_dump(2'd0, 1'b0, e);
    exp_cnt++;
    chk("b2b_edges", 32'(e), 32'd33);
    chk("b2b_count", 32'(dump_count), 32'(exp_cnt));
    chk("b2b_halted", 32'(halted), 32'd1);
    chk("b2b_halt", 32'(halt), 32'd1);
    repeat (3) @(negedge clk);
    chk("b2b_no_third", 32'(out_valid), 32'd0);

    // reset in the middle of a snapshot
    pulse_req();
    e = 0;
    while (!(out_valid && out_idx == 5'd10) && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk("rst_reach10", 32'(out_idx), 32'd10);
    resetn = 1'b0;
    #1;
    chk("mid_halt", 32'(halt), 32'd0);
    chk("mid_halted", 32'(halted), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_data", out_data, 32'd0);
    chk("mid_idx", 32'(out_idx), 32'd0);
    chk("mid_last", 32'(out_last), 32'd0);
    chk("mid_cause", 32'(out_cause), 32'd0);
    chk("mid_raddr", 32'(rf_raddr), 32'd0);
    chk("mid_count", 32'(dump_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_halt", 32'(halt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
